// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between the four sources and the round-robin mux arbiter.
// The arbiter connects through the slave modport; the sources use the master modport.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [3:0]       gnt;
  logic             valid;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] out;
  logic             timeout;

  modport master (
    output req, i0, i1, i2, i3,
    input  gnt, valid, s0, s1, out, timeout
  );

  modport slave (
    input  req, i0, i1, i2, i3,
    output gnt, valid, s0, s1, out, timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and 4-to-1 data mux driven from a registered one-hot grant.
// Optional MUX_ARB_TIMEOUT_EN: forces release after MAX_HOLD cycles while others wait.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mux4_rr_arbiter_if.slave     bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] others_s;
  logic [2:0] pick_s;
  logic [2:0] nxt_s;
  logic       force_s;
  logic [WIDTH-1:0] out_s;

  // First set request at or after start, modulo 4; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int j = 3; j >= 0; j--) begin
      k = start + 2'(j);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign others_s = bus.req & ~(4'b0001 << sel_q);
  assign pick_s   = rr_pick(bus.req, ptr_q);
  assign nxt_s    = rr_pick(others_s, sel_q + 2'd1);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  assign force_s = (hold_q == HW'(MAX_HOLD - 1)) && (others_s != 4'b0000);
`else
  assign force_s = 1'b0;
`endif

  // Next-state, grant and pointer selection.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          state_d = GRANT;
          sel_d   = pick_s[1:0];
          gnt_d   = 4'b0001 << pick_s[1:0];
`ifdef MUX_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || force_s) begin
          ptr_d = sel_q + 2'd1;
          if (nxt_s[2]) begin
            sel_d = nxt_s[1:0];
            gnt_d = 4'b0001 << nxt_s[1:0];
`ifdef MUX_ARB_TIMEOUT_EN
            hold_d    = '0;
            timeout_d = bus.req[sel_q];
`endif
          end else begin
            state_d = IDLE;
            sel_d   = 2'd0;
            gnt_d   = 4'b0000;
          end
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          // Saturate so a sole requester is never preempted.
          if (hold_q != HW'(MAX_HOLD - 1)) hold_d = hold_q + HW'(1);
          else hold_d = hold_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Hold counter and timeout pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  // Data mux from the registered select and live inputs.
  always_comb begin
    out_s = {WIDTH{1'b0}};
    if (gnt_q != 4'b0000) begin
      case (sel_q)
        2'd0:    out_s = bus.i0;
        2'd1:    out_s = bus.i1;
        2'd2:    out_s = bus.i2;
        2'd3:    out_s = bus.i3;
        default: out_s = {WIDTH{1'b0}};
      endcase
    end else begin
      out_s = {WIDTH{1'b0}};
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.valid = |gnt_q;
  assign bus.s0    = sel_q[1];
  assign bus.s1    = sel_q[0];
  assign bus.out   = out_s;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mux4_rr_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mux4_rr_arbiter_if #(.WIDTH(8)) bus();

  mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       valid;
    logic [7:0] outv;
  } vec_t;

  vec_t vec [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [3:0] g, input logic s0,
                         input logic s1, input logic v, input logic [7:0] o);
    chk({name, ".gnt"},   32'(bus.gnt),   32'(g));
    chk({name, ".s0"},    32'(bus.s0),    32'(s0));
    chk({name, ".s1"},    32'(bus.s1),    32'(s1));
    chk({name, ".valid"}, 32'(bus.valid), 32'(v));
    chk({name, ".out"},   32'(bus.out),   32'(o));
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req = 4'b0000;
    bus.i0 = 8'hA5;
    bus.i1 = 8'h3C;
    bus.i2 = 8'h5A;
    bus.i3 = 8'hC3;

    vec[0] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'hA5};
    vec[1] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vec[2] = '{4'b0110, 4'b0010, 1'b0, 1'b1, 1'b1, 8'h3C};
    vec[3] = '{4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 8'h5A};
    vec[4] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vec[5] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'hA5};
    vec[6] = '{4'b0011, 4'b0001, 1'b0, 1'b0, 1'b1, 8'hA5};
    vec[7] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 8'h3C};
    vec[8] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};

    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset.timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus.req = vec[i].req;
      step();
      chk_all($sformatf("vec%0d", i), vec[i].gnt, vec[i].s0, vec[i].s1, vec[i].valid, vec[i].outv);
      chk($sformatf("vec%0d.timeout", i), 32'(bus.timeout), 32'd0);
    end

    // All four requesting; each owner drops one cycle after its grant.
    do_reset();
    bus.req = 4'b1111;
    step();
    chk_all("rr0", 4'b0001, 1'b0, 1'b0, 1'b1, 8'hA5);
    bus.req = 4'b1110;
    step();
    chk_all("rr1", 4'b0010, 1'b0, 1'b1, 1'b1, 8'h3C);
    bus.req = 4'b1100;
    step();
    chk_all("rr2", 4'b0100, 1'b1, 1'b0, 1'b1, 8'h5A);
    bus.req = 4'b1000;
    step();
    chk_all("rr3", 4'b1000, 1'b1, 1'b1, 1'b1, 8'hC3);
    bus.req = 4'b0111;
    step();
    chk_all("rr4", 4'b0001, 1'b0, 1'b0, 1'b1, 8'hA5);

    // Two requesters held: hold limit behaviour.
    do_reset();
    bus.req = 4'b0011;
    step();
    chk("hold.c1", 32'(bus.gnt), 32'h1);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("hold.c%0d", c), 32'(bus.gnt), 32'h1);
      chk($sformatf("hold.to%0d", c), 32'(bus.timeout), 32'd0);
    end
`ifdef MUX_ARB_TIMEOUT_EN
    step();
    chk("hold.forced", 32'(bus.gnt), 32'h2);
    chk("hold.pulse", 32'(bus.timeout), 32'd1);
    step();
    chk("hold.after", 32'(bus.gnt), 32'h2);
    chk("hold.pulse_end", 32'(bus.timeout), 32'd0);
`else
    for (int c = 5; c <= 14; c++) begin
      step();
      chk($sformatf("hold.c%0d", c), 32'(bus.gnt), 32'h1);
      chk($sformatf("hold.to%0d", c), 32'(bus.timeout), 32'd0);
    end
`endif

    // Sole requester is never preempted.
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("sole.gnt%0d", c), 32'(bus.gnt), 32'h4);
      chk($sformatf("sole.to%0d", c), 32'(bus.timeout), 32'd0);
    end

    // Reset mid-grant, then confirm the pointer restarts at 0.
    do_reset();
    bus.req = 4'b0010;
    step();
    chk("mid.g1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    step();
    chk("mid.idle", 32'(bus.gnt), 32'h0);
    bus.req = 4'b0100;
    step();
    chk("mid.g2", 32'(bus.gnt), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    chk_all("mid.rst", 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b0101;
    step();
    chk_all("mid.ptr0", 4'b0001, 1'b0, 1'b0, 1'b1, 8'hA5);
    bus.req = 4'b1000;
    step();
    chk_all("mid.g3", 4'b1000, 1'b1, 1'b1, 1'b1, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
